adc_capture: RTL and testbench
==============================

# adc_capture

Multi-channel successor to the single-bit ADC sampling flop. Samples CHANNELS delta-sigma comparator bitstreams through a per-channel synchronizer and counts ones over a fixed OSR-cycle window, a first-order decimator. Presents one parallel result word per window through a valid/ready holding register with a sticky overrun flag. Sits between the analog comparator pins and the downstream filter/register block.

## Interface
- CHANNELS, 4: number of comparator inputs.
- OSR, 256: window length in enabled cycles; must be ≥ 2.
- SYNC_STAGES, 2: synchronizer flops per channel; must be ≥ 2.
- Derived W = $clog2(OSR+1): per-channel result width.

- clk  input  1  sole clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- en  input  1  capture enable; 0 aborts and holds the window at start.
- adc  input  CHANNELS  raw comparator bits, asynchronous to clk.
- sampleReady  input  1  consumer accepts sampleData this cycle.
- clrOverrun  input  1  synchronous clear of overrun.
- sampleData  output  CHANNELS*W  channel c in bits [c*W +: W].
- sampleValid  output  1  sampleData holds an unconsumed result.
- overrun  output  1  sticky; a window result was dropped.

## Operation
- Reset (rst=0): all synchronizer flops, accumulators, phase counter, sampleData, sampleValid and overrun go to 0.
- Synchronizer: adc[c] passes through SYNC_STAGES flops. syncBit[c] is the last stage.
- Phase counter: 0..OSR-1. It increments on each cycle with en=1 and wraps to 0 after OSR-1.
- Accumulator per channel, W bits: adds syncBit[c] on each en=1 cycle. It cannot overflow because the maximum value is OSR.
- Window end is a cycle with en=1 and phase=OSR-1. On that cycle:
  - result[c] = acc[c] + syncBit[c].
  - acc[c] clears to 0, so the next window starts fresh.
  - phase wraps to 0.
- Load rule at window end:
  - If sampleValid=0, or sampleValid=1 and sampleReady=1 in the same cycle, load result into sampleData and set sampleValid=1. No overrun.
  - If sampleValid=1 and sampleReady=0, discard the new result. sampleData stays unchanged and overrun is set to 1.
- Handshake: sampleValid=1 and sampleReady=1 with no window end clears sampleValid next cycle. sampleData must not change while sampleValid=1 unless the load rule above fires.
- en=0: phase and all accumulators clear to 0 synchronously, so the partial window is discarded. Synchronizers keep running. sampleData, sampleValid, handshake and overrun are unaffected.
- overrun: set by a dropped result. Cleared by clrOverrun=1 on the next edge. If set and clear occur in the same cycle, set wins.

## Timing
- adc edge to syncBit: SYNC_STAGES cycles.
- Window = exactly OSR consecutive en=1 cycles, counted from reset release or from en rising.
- sampleValid rises on the edge that ends the window, i.e. it is visible the cycle after the last window cycle. No added pipeline.
- Back-to-back windows need no gap; the next window's first cycle is the cycle after the window end.
- The first window after reset includes up to SYNC_STAGES zero bits from the synchronizer flush.
- Asserting reset mid-window or mid-handshake loses all state immediately. Counting restarts at phase 0 on the first enabled edge after release.
- sampleReady with sampleValid=0 has no effect.

## Test plan
- Use CHANNELS=2, OSR=8, SYNC_STAGES=2 (W=4) unless noted.
- Constant input, ready=1: adc=2'b01 held and en=1 after flush -> each window gives ch0=8, ch1=0, with sampleValid pulsing one cycle every 8 cycles.
- Alternating ch1 (1,0,1,0...) with ch0=1 -> ch1=4 and ch0=8 per window. For OSR=256, all ones gives 256 (W=9) with no wrap.
- Overrun: sampleReady=0 across two window ends -> first result held unchanged, overrun=1 after the second end. clrOverrun=1 -> overrun=0 next cycle and sampleData still equals the first result.
- Simultaneous events: sampleReady=1 on the window-end cycle with sampleValid=1 -> new result loaded, sampleValid stays 1, overrun stays 0.
- en dropped at phase 5 for 3 cycles, then restored -> no result from the partial window. The next result arrives exactly 8 enabled cycles after en rises, and the pending sampleValid/sampleData are unchanged throughout.
- rst=0 asynchronously at phase 3 with sampleValid=1 -> all outputs 0 immediately. After release with adc=2'b11, the first result is 6 per channel (2 flush zeros), and later results are 8.

Source files
------------

// File: rtl/adc_capture.sv
// Multi-channel first-order delta-sigma decimator: synchronizes each comparator bit,
// counts ones over OSR enabled cycles and presents one result word per window via valid/ready.
module adc_capture #(
    parameter int CHANNELS    = 4,
    parameter int OSR         = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [CHANNELS-1:0]               adc,
    input  logic                              sampleReady,
    input  logic                              clrOverrun,
    output logic [CHANNELS*$clog2(OSR+1)-1:0] sampleData,
    output logic                              sampleValid,
    output logic                              overrun
);
    localparam int W  = $clog2(OSR + 1);
    localparam int PW = $clog2(OSR);
    localparam logic [PW-1:0] LAST_PHASE = PW'(OSR - 1);

    logic [CHANNELS-1:0]   r_sync [SYNC_STAGES];
    logic [PW-1:0]         r_phase;
    logic [W-1:0]          r_acc [CHANNELS];
    logic [CHANNELS*W-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;

    logic [CHANNELS-1:0]   w_sync_bit;
    logic                  w_window_end;
    logic                  w_load;
    logic                  w_drop;
    logic [CHANNELS*W-1:0] w_result;

    assign w_sync_bit   = r_sync[SYNC_STAGES-1];
    assign w_window_end = en && (r_phase == LAST_PHASE);
    assign w_load       = w_window_end && (!r_valid || sampleReady);
    assign w_drop       = w_window_end && r_valid && !sampleReady;

    // The last bit of the window is folded in here so the result needs no extra cycle.
    always_comb begin
        w_result = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_result[c*W +: W] = r_acc[c] + W'(w_sync_bit[c]);
        end
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values;
    // the synchronizer chain only shifts correctly because of that.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= adc;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // NOTE: the accumulator array is small register state, not RAM, so it is reset like any flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= '0;
            end
        end else if (!en || w_window_end) begin
            r_phase <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= '0;
            end
        end else begin
            r_phase <= r_phase + PW'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= r_acc[c] + W'(w_sync_bit[c]);
            end
        end
    end

    // A window end with ready=1 always loads, so a plain ready here is a pure consume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= w_result;
                r_valid <= 1'b1;
            end else if (sampleReady) begin
                r_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clrOverrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign sampleData  = r_data;
    assign sampleValid = r_valid;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: a cycle-level window model checked every cycle, plus directed
// scenarios with hand-computed literal results (CHANNELS=2, OSR=8, SYNC_STAGES=2).
module tb_adc_capture;
    localparam int CH  = 2;
    localparam int OSR = 8;
    localparam int SS  = 2;
    localparam int W   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [CH-1:0] adc = '0;
    logic          sampleReady = 1'b0;
    logic          clrOverrun = 1'b0;
    logic [CH*W-1:0] sampleData;
    logic          sampleValid;
    logic          overrun;

    // Wide-window instance: one channel, OSR=256, to show a full count of 256 does not wrap.
    logic       en2 = 1'b0;
    logic [0:0] adc2 = 1'b1;
    logic [8:0] data2;
    logic       valid2;
    logic       ovr2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    adc_capture #(.CHANNELS(CH), .OSR(OSR), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .en(en), .adc(adc),
        .sampleReady(sampleReady), .clrOverrun(clrOverrun),
        .sampleData(sampleData), .sampleValid(sampleValid), .overrun(overrun)
    );

    adc_capture #(.CHANNELS(1), .OSR(256), .SYNC_STAGES(2)) dut_wide (
        .clk(clk), .rst(rst), .en(en2), .adc(adc2),
        .sampleReady(1'b1), .clrOverrun(1'b0),
        .sampleData(data2), .sampleValid(valid2), .overrun(ovr2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: the comparator value seen by the counter is adc delayed SS edges;
    // a window is OSR consecutive enabled edges counted with plain integers.
    logic [CH-1:0]   m_hist [SS];
    logic [CH-1:0]   m_bit;
    int              m_cnt;
    int              m_ones [CH];
    logic            m_valid;
    logic            m_ovr;
    logic [CH*W-1:0] m_data;
    bit              m_wend;
    bit              m_drop;

    initial begin
        m_cnt = 0; m_valid = 0; m_ovr = 0; m_data = '0;
        for (int c = 0; c < CH; c++) m_ones[c] = 0;
        for (int s = 0; s < SS; s++) m_hist[s] = '0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_cnt = 0; m_valid = 0; m_ovr = 0; m_data = '0;
                for (int c = 0; c < CH; c++) m_ones[c] = 0;
                for (int s = 0; s < SS; s++) m_hist[s] = '0;
            end else begin
                m_bit = m_hist[SS-1];
                for (int s = SS - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
                m_hist[0] = adc;
                m_wend = 0;
                m_drop = 0;
                if (en) begin
                    for (int c = 0; c < CH; c++) m_ones[c] += int'(m_bit[c]);
                    m_cnt++;
                    if (m_cnt == OSR) begin
                        m_wend = 1;
                        if (!m_valid || sampleReady) begin
                            for (int c = 0; c < CH; c++) m_data[c*W +: W] = m_ones[c][W-1:0];
                            m_valid = 1;
                        end else begin
                            m_drop = 1;
                        end
                        m_cnt = 0;
                        for (int c = 0; c < CH; c++) m_ones[c] = 0;
                    end
                end else begin
                    m_cnt = 0;
                    for (int c = 0; c < CH; c++) m_ones[c] = 0;
                end
                if (!m_wend && m_valid && sampleReady) m_valid = 0;
                if (m_drop) m_ovr = 1;
                else if (clrOverrun) m_ovr = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cyc_valid", 32'(sampleValid), 32'(m_valid));
            check("cyc_overrun", 32'(overrun), 32'(m_ovr));
            check("cyc_data", 32'(sampleData), 32'(m_data));
        end
    end

    task automatic wait_valid(input int max, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sampleValid && k < max);
        check({name, "_timeout"}, 32'(sampleValid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        int k;

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(sampleValid), 32'd0);
        check("rst_data", 32'(sampleData), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;

        // Constant input, ready=1: ch0=8, ch1=0, one-cycle pulse every 8 cycles.
        sampleReady = 1'b1;
        adc = 2'b01;
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_valid(20, "const_first");
        check("const_data", 32'(sampleData), 32'h08);
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (sampleValid) hits++;
        end
        check("const_pulses", 32'(hits), 32'd2);

        // Alternating ch1 with ch0 held high: ch1=4, ch0=8 per window.
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i >= 5 && sampleValid) begin
                hits++;
                check("alt_data", 32'(sampleData), 32'h48);
            end
            adc = {i[0], 1'b1};
            en = (i >= 3);
        end
        check("alt_windows", 32'(hits >= 2), 32'd1);

        // Overrun: ready low across two window ends keeps the first result.
        @(negedge clk);
        sampleReady = 1'b0;
        adc = 2'b01;
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_valid(20, "ovr_first");
        check("ovr_first_data", 32'(sampleData), 32'h08);
        adc = 2'b10;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!overrun && k < 20);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_held_data", 32'(sampleData), 32'h08);
        check("ovr_held_valid", 32'(sampleValid), 32'd1);
        clrOverrun = 1'b1;
        @(negedge clk);
        clrOverrun = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
        check("ovr_clr_data", 32'(sampleData), 32'h08);
        en = 1'b0;

        // Ready on the window-end cycle with a pending result: reload, no overrun.
        @(negedge clk);
        en = 1'b1;
        repeat (7) @(negedge clk);
        check("simul_pre_data", 32'(sampleData), 32'h08);
        sampleReady = 1'b1;
        @(negedge clk);
        sampleReady = 1'b0;
        check("simul_valid", 32'(sampleValid), 32'd1);
        check("simul_data", 32'(sampleData), 32'h80);
        check("simul_overrun", 32'(overrun), 32'd0);

        // en dropped at phase 5 for 3 cycles: partial window discarded, pending result kept.
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b0;
        adc = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("endrop_valid", 32'(sampleValid), 32'd1);
            check("endrop_data", 32'(sampleData), 32'h80);
        end
        en = 1'b1;
        repeat (7) @(negedge clk);
        check("endrop_pre_data", 32'(sampleData), 32'h80);
        check("endrop_pre_overrun", 32'(overrun), 32'd0);
        sampleReady = 1'b1;
        @(negedge clk);
        sampleReady = 1'b0;
        check("endrop_new_data", 32'(sampleData), 32'h88);
        check("endrop_new_valid", 32'(sampleValid), 32'd1);

        // Asynchronous reset mid-window with a pending result.
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 32'(sampleValid), 32'd0);
        check("arst_data", 32'(sampleData), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        sampleReady = 1'b1;
        wait_valid(20, "arst_first");
        check("arst_first_data", 32'(sampleData), 32'h66);
        wait_valid(20, "arst_second");
        check("arst_second_data", 32'(sampleData), 32'h88);

        // OSR=256 with all ones gives 256 in a 9-bit field.
        en2 = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!valid2 && k < 300);
        check("wide_valid", 32'(valid2), 32'd1);
        check("wide_data", 32'(data2), 32'd256);
        check("wide_overrun", 32'(ovr2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
